// File: rtl/memoria_pkg.sv
// Shared constants for the synchronous instruction memory: NOP word, fault codes,
// RV32I major opcodes and the bit positions of the decode fields.
package memoria_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [1:0] FAULT_OK       = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE    = 2'b10;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam int unsigned OPCODE_LSB = 0;
    localparam int unsigned OPCODE_W   = 7;
    localparam int unsigned RD_LSB     = 7;
    localparam int unsigned RD_W       = 5;
    localparam int unsigned FUNCT3_LSB = 12;
    localparam int unsigned FUNCT3_W   = 3;
    localparam int unsigned RS1_LSB    = 15;
    localparam int unsigned RS1_W      = 5;
    localparam int unsigned RS2_LSB    = 20;
    localparam int unsigned RS2_W      = 5;
    localparam int unsigned FUNCT7_LSB = 25;
    localparam int unsigned FUNCT7_W   = 7;

    typedef enum logic [0:0] {
        StClear,
        StRun
    } state_e;

    // Classify a fetch byte address; misalignment wins over range.
    function automatic logic [1:0] classify(input logic misaligned, input logic out_of_range);
        if (misaligned) begin
            return FAULT_MISALIGN;
        end else if (out_of_range) begin
            return FAULT_RANGE;
        end
        return FAULT_OK;
    endfunction

endpackage

// File: rtl/memoria_ins_array.sv
// Single-port DEPTH x 32 synchronous RAM with registered read data.
// The read register only updates on a read-only cycle so it can hold a stalled response.
module memoria_ins_array #(
    parameter  int unsigned DEPTH = 64,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic             re,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/memoria_ins_sync.sv
// Clocked instruction memory: post-reset NOP clear, program-load port and a
// valid/ready fetch path with a single-entry response buffer and pre-split fields.
module memoria_ins_sync
    import memoria_pkg::*;
#(
    parameter  int unsigned ADDR_W = 32,
    parameter  int unsigned DEPTH  = 64,
    localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              busy,
    input  logic              load_en,
    input  logic [IDX_W-1:0]  load_idx,
    input  logic [31:0]       load_data,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] ads,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       dout,
    output logic [6:0]        opcode,
    output logic [4:0]        rd,
    output logic [2:0]        funct3,
    output logic [4:0]        rs1,
    output logic [4:0]        rs2,
    output logic [6:0]        funct7,
    output logic [1:0]        fault
);

    state_e            state_q;
    logic [IDX_W-1:0]  clr_cnt_q;
    logic              busy_q;
    logic              resp_valid_q;
    logic [1:0]        fault_q;

    logic [ADDR_W-3:0] word_idx;
    logic              misaligned;
    logic              out_of_range;
    logic [1:0]        req_fault;
    logic              accept;

    logic              ram_we;
    logic              ram_re;
    logic [IDX_W-1:0]  ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    // Range check looks at the whole word index, not just the bits that address the array.
    assign word_idx     = ads[ADDR_W-1:2];
    assign misaligned   = (ads[1:0] != 2'b00);
    assign out_of_range = ((word_idx >> IDX_W) != '0);
    assign req_fault    = classify(misaligned, out_of_range);

    assign req_ready = (state_q == StRun) && !reset && !load_en && (!resp_valid_q || resp_ready);
    assign accept    = req_valid && req_ready;

    // Port arbitration: clear > load > fetch.
    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = word_idx[IDX_W-1:0];
        ram_wdata = NOP;
        if (!reset) begin
            if (state_q == StClear) begin
                ram_we   = 1'b1;
                ram_addr = clr_cnt_q;
            end else if (load_en) begin
                ram_we    = 1'b1;
                ram_addr  = load_idx;
                ram_wdata = load_data;
            end else if (accept && (req_fault == FAULT_OK)) begin
                ram_re = 1'b1;
            end
        end
    end

    memoria_ins_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StClear;
            clr_cnt_q    <= '0;
            busy_q       <= 1'b1;
            resp_valid_q <= 1'b0;
            fault_q      <= FAULT_OK;
        end else begin
            unique case (state_q)
                StClear: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
                        state_q <= StRun;
                        busy_q  <= 1'b0;
                    end
                end
                StRun: begin
                    if (accept) begin
                        resp_valid_q <= 1'b1;
                        fault_q      <= req_fault;
                    end else if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StClear;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    // A faulted fetch never reads the array, so the stale read register is masked here.
    assign dout = (fault_q == FAULT_OK) ? ram_rdata : NOP;

    assign busy       = busy_q;
    assign resp_valid = resp_valid_q;
    assign fault      = fault_q;
    assign opcode     = dout[OPCODE_LSB +: OPCODE_W];
    assign rd         = dout[RD_LSB +: RD_W];
    assign funct3     = dout[FUNCT3_LSB +: FUNCT3_W];
    assign rs1        = dout[RS1_LSB +: RS1_W];
    assign rs2        = dout[RS2_LSB +: RS2_W];
    assign funct7     = dout[FUNCT7_LSB +: FUNCT7_W];

endmodule

// File: tb/tb_memoria_ins_sync.sv
// Scoreboard bench for memoria_ins_sync: expected {fault, word} pushed at request
// acceptance, popped and compared at the response handshake.
module tb_memoria_ins_sync;

    localparam int unsigned DEPTH  = 64;
    localparam int unsigned ADDR_W = 32;
    localparam logic [31:0] NOP_W  = 32'h0000_0013;
    localparam logic [31:0] ADD_W  = 32'h0080_84B3;
    localparam logic [31:0] SUB_W  = 32'h4014_0533;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_en = 1'b0;
    logic [5:0]  load_idx = '0;
    logic [31:0] load_data = '0;
    logic        req_valid = 1'b0;
    logic [31:0] ads = '0;
    logic        resp_ready = 1'b1;

    logic        busy, req_ready, resp_valid;
    logic [31:0] dout;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [1:0]  fault;

    int n_tests = 0;
    int n_fail  = 0;

    logic [33:0] sb_q[$];
    logic [31:0] mem_model [DEPTH];

    memoria_ins_sync #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .busy       (busy),
        .load_en    (load_en),
        .load_idx   (load_idx),
        .load_data  (load_data),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .ads        (ads),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .dout       (dout),
        .opcode     (opcode),
        .rd         (rd),
        .funct3     (funct3),
        .rs1        (rs1),
        .rs2        (rs2),
        .funct7     (funct7),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [33:0] expect_for(input logic [31:0] a);
        if (a[1:0] != 2'b00) return {2'b01, NOP_W};
        if (a[31:2] >= 30'(DEPTH)) return {2'b10, NOP_W};
        return {2'b00, mem_model[a[7:2]]};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) mem_model[i] = NOP_W;
    endtask

    // One cycle from a negedge to the next; handshakes judged just before the rising edge.
    task automatic tick(output logic acc);
        logic [33:0] e;
        #1;
        acc = req_valid && req_ready;
        if (resp_valid && resp_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_resp", 32'(1), 32'(0));
            end else begin
                e = sb_q.pop_front();
                check("dout", dout, e[31:0]);
                check("fault", 32'(fault), 32'(e[33:32]));
                check("opcode", 32'(opcode), 32'(e[6:0]));
                check("rd", 32'(rd), 32'(e[11:7]));
                check("funct3", 32'(funct3), 32'(e[14:12]));
                check("rs1", 32'(rs1), 32'(e[19:15]));
                check("rs2", 32'(rs2), 32'(e[24:20]));
                check("funct7", 32'(funct7), 32'(e[31:25]));
            end
        end
        if (acc) sb_q.push_back(expect_for(ads));
        if (load_en && !busy) mem_model[load_idx] = load_data;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fetch(input logic [31:0] a);
        logic acc = 1'b0;
        req_valid = 1'b1;
        ads = a;
        for (int n = 0; n < 20 && !acc; n++) tick(acc);
        req_valid = 1'b0;
        check("req_accept", 32'(acc), 32'(1));
        if (acc) check("resp_valid_latency", 32'(resp_valid), 32'(1));
    endtask

    task automatic load(input logic [5:0] idx, input logic [31:0] data);
        logic acc;
        load_en = 1'b1;
        load_idx = idx;
        load_data = data;
        tick(acc);
        load_en = 1'b0;
    endtask

    task automatic drain();
        logic acc;
        for (int n = 0; n < 10 && sb_q.size() != 0; n++) tick(acc);
        check("sb_drain", 32'(sb_q.size()), 32'(0));
    endtask

    // Counts busy cycles; pokes a load mid-clear that must be ignored.
    task automatic wait_clear(input string tag);
        int cnt = 0;
        while (busy && cnt < 200) begin
            if (cnt == 50) begin
                load_en = 1'b1;
                load_idx = 6'd3;
                load_data = 32'hDEAD_BEEF;
            end else begin
                load_en = 1'b0;
            end
            check({tag, "_ready_low"}, 32'(req_ready), 32'(0));
            cnt++;
            @(posedge clk);
            @(negedge clk);
        end
        load_en = 1'b0;
        check({tag, "_cycles"}, 32'(cnt), 32'(DEPTH));
        check({tag, "_ready_after"}, 32'(req_ready), 32'(1));
    endtask

    initial begin
        logic acc;
        logic [31:0] held;

        model_clear();
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'(1));
        check("rst_req_ready", 32'(req_ready), 32'(0));
        check("rst_resp_valid", 32'(resp_valid), 32'(0));
        check("rst_dout", dout, 32'h0);
        check("rst_fault", 32'(fault), 32'(0));
        check("rst_fields", {opcode, rd, funct3, rs1, rs2, funct7}, 32'h0);
        reset = 1'b0;
        wait_clear("clear");

        // Back-to-back NOP fetches after clear, including word 3 poked during clear.
        fetch(32'd0);
        fetch(32'd4);
        fetch(32'd8);
        fetch(32'd12);
        drain();

        load(6'd0, ADD_W);
        load(6'd1, SUB_W);
        fetch(32'd0);
        fetch(32'd4);
        drain();

        fetch(32'd2);
        fetch(32'd256);
        fetch(32'd257);
        fetch(32'd252);
        drain();

        // Stall with a load to the held word.
        resp_ready = 1'b0;
        fetch(32'd0);
        held = sb_q[0][31:0];
        req_valid = 1'b1;
        ads = 32'd4;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                load_en = 1'b1;
                load_idx = 6'd0;
                load_data = 32'hFFFF_FFFF;
            end else begin
                load_en = 1'b0;
            end
            #1;
            check("stall_req_ready", 32'(req_ready), 32'(0));
            check("stall_dout", dout, held);
            check("stall_resp_valid", 32'(resp_valid), 32'(1));
            tick(acc);
            check("stall_no_accept", 32'(acc), 32'(0));
        end
        load_en = 1'b0;
        req_valid = 1'b0;
        resp_ready = 1'b1;
        drain();
        fetch(32'd0);
        drain();

        // Load and request in the same cycle.
        load_en = 1'b1;
        load_idx = 6'd5;
        load_data = 32'h00A0_0093;
        req_valid = 1'b1;
        ads = 32'd20;
        #1;
        check("load_blocks_ready", 32'(req_ready), 32'(0));
        tick(acc);
        check("load_blocks_accept", 32'(acc), 32'(0));
        load_en = 1'b0;
        #1;
        check("after_load_ready", 32'(req_ready), 32'(1));
        tick(acc);
        check("after_load_accept", 32'(acc), 32'(1));
        req_valid = 1'b0;
        drain();
        check("resp_cleared", 32'(resp_valid), 32'(0));

        // Reset during streaming fetches.
        load(6'd2, 32'h1234_5678);
        req_valid = 1'b1;
        ads = 32'd8;
        tick(acc);
        ads = 32'd4;
        tick(acc);
        ads = 32'd0;
        tick(acc);
        reset = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_resp_valid", 32'(resp_valid), 32'(0));
        check("midrst_busy", 32'(busy), 32'(1));
        check("midrst_req_ready", 32'(req_ready), 32'(0));
        sb_q.delete();
        model_clear();
        reset = 1'b0;
        wait_clear("reclear");
        fetch(32'd8);
        fetch(32'd0);
        fetch(32'd20);
        drain();
        check("final_resp_cleared", 32'(resp_valid), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/memoria_ins_sync.md
# memoria_ins_sync

Parametrised, clocked successor to the combinational instruction memory. It holds DEPTH 32-bit RISC-V instruction words. It accepts byte-addressed fetch requests from the PC stage through a valid/ready handshake and returns the instruction plus pre-split decode fields one cycle later. It also provides a program-load write port and clears itself to NOP after reset. It sits between the PC register and the IR/decode stage of the single-cycle and multicycle datapaths.

## Interface
- ADDR_W, 32, width of fetch byte address (PC)
- DEPTH, 64, number of instruction words; power of two, ≥ 4
- IDX_W, $clog2(DEPTH), derived word-index width (localparam)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- busy  out  1  high while post-reset clear is in progress
- load_en  in  1  write load_data into word load_idx this cycle
- load_idx  in  IDX_W  word index for program load
- load_data  in  32  instruction word to write
- req_valid  in  1  fetch request valid
- req_ready  out  1  fetch request accepted when valid&&ready
- ads  in  ADDR_W  fetch byte address
- resp_valid  out  1  response valid
- resp_ready  in  1  consumer accepts response
- dout  out  32  instruction word (to IR)
- opcode  out  7  dout[6:0]
- rd  out  5  dout[11:7]
- funct3  out  3  dout[14:12]
- rs1  out  5  dout[19:15]
- rs2  out  5  dout[24:20]
- funct7  out  7  dout[31:25]
- fault  out  2  00 ok, 01 misaligned, 10 out of range (valid with resp_valid)

## Operation
- FSM states CLEAR and RUN. Reset enters CLEAR with clear counter = 0.
- CLEAR: writes NOP (32'h00000013) to word counter each cycle and increments the counter. It moves to RUN after writing word DEPTH-1, so CLEAR lasts exactly DEPTH cycles. busy=1, req_ready=0, load_en ignored.
- RUN: busy=0.
  - load_en=1 writes memory and forces req_ready=0 that cycle. Load has priority over fetch.
  - Otherwise req_ready = !resp_valid || resp_ready, giving a single-entry output buffer.
- Address rules:
  - Word index = ads[ADDR_W-1:2].
  - If ads[1:0]≠0, fault=01. Otherwise, if the full word index ≥ DEPTH, fault=10 (the check uses the untruncated index).
  - Any fault: dout=NOP, memory is not read.
  - Misaligned takes precedence over out of range.
- Decode fields are always the slices of the registered dout, never of the array.
- Stall: while resp_valid && !resp_ready, dout/fault/fields hold. A load to the same word does not alter the held response.

## Timing
- Reset values: busy=1, req_ready=0, resp_valid=0, dout=0, all fields 0, fault=00. Memory contents are undefined until the CLEAR pass completes.
- First cycle with req_ready=1 is DEPTH cycles after reset deasserts.
- Fetch latency is 1 cycle: a request accepted at edge N gives resp_valid=1 and data after edge N, visible in cycle N+1.
- Back-to-back: with resp_ready held high, one response per cycle.
- Load write is visible to a fetch accepted on the next cycle or later.
- Response clears: resp_valid falls after the edge where resp_valid&&resp_ready and no new request is accepted.
- Reset mid-operation: resp_valid drops, the pending response is discarded, and a full CLEAR pass restarts. Previously loaded program is overwritten with NOP.

## Structure
- Shared package memoria_pkg holds:
  - NOP constant 32'h00000013
  - fault encodings FAULT_OK/FAULT_MISALIGN/FAULT_RANGE
  - opcode localparams (OP_R 0110011, OP_I 0010011, OP_LOAD 0000011, OP_STORE 0100011, OP_BRANCH 1100011, OP_JAL 1101111, OP_JALR 1100111, OP_AUIPC 0010111)
  - field slice constants
- Sub-module memoria_ins_array is a single-port synchronous RAM: DEPTH×32, write enable, registered read. It is shared by clear, load and fetch through a priority mux (clear > load > fetch).
- Top holds the FSM, clear counter, address checks, handshake and output buffer.

## Test plan
- Reset, then 4 fetches at ads 0,4,8,12 with DEPTH=64: busy for 64 cycles; each dout=32'h00000013, opcode=0010011, fault=00.
- Load idx0=32'h00808_4B3 (ADD x9,x1,x8 = {0000000,01000,00001,000,01001,0110011}) and idx1 SUB x10,x8,x1. Fetch ads 0 then 4: dout matches, rd=9/10, rs1=1/8, rs2=8/1, funct7=0000000/0100000.
- Fetch ads=2: fault=01, dout=NOP. Fetch ads=256 (DEPTH=64): fault=10, dout=NOP. Fetch ads=257: fault=01.
- Hold resp_ready=0 for 5 cycles after a fetch of word 0 while loading word 0 with 32'hFFFFFFFF: req_ready=0, dout unchanged. Then fetch ads 0 again: dout=32'hFFFFFFFF.
- load_en and req_valid in the same cycle: the request is not accepted (req_ready=0), the load completes, and the request is accepted the next cycle.
- Assert reset during streaming fetches: resp_valid=0 the next cycle and busy=1 for DEPTH cycles. Previously loaded words read back as NOP.
